serial_subtractor: RTL and testbench

//   Multi-cycle digit-serial subtractor: diff = ain - bin - bin_in, DIGIT bits per clock, LSB digit first.

---
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial subtractor (ain - bin - bin_in), LSB digit first
// Optional zero/ovf flag outputs enabled by defining SERIAL_SUB_FLAGS_EN.
module serial_subtractor #(
  parameter int WIDTH = 24,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic             bin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = WIDTH - DIGIT;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [SW-1:0]    shadow;
  logic [WIDTH-1:0] shadow_full;
  logic             brw;
  logic [DIGIT:0]   dsum;
  logic             last;

  assign last        = (cnt == CW'(N - 1));
  assign dsum        = {1'b0, a_sh[DIGIT-1:0]} - {1'b0, b_sh[DIGIT-1:0]} - {{DIGIT{1'b0}}, brw};
  // New digit enters at the top; after N digits the LSB digit has reached bit 0.
  assign shadow_full = {dsum[DIGIT-1:0], shadow};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      brw    <= 1'b0;
      shadow <= '0;
      diff   <= '0;
      borrow <= 1'b0;
    end else if (state == IDLE) begin
      if (start) begin
        cnt    <= '0;
        a_sh   <= ain;
        b_sh   <= bin;
        brw    <= bin_in;
        shadow <= '0;
      end
    end else if (state == RUN) begin
      cnt    <= last ? '0 : cnt + 1'b1;
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      brw    <= dsum[DIGIT];
      shadow <= shadow_full[WIDTH-1:DIGIT];
      if (last) begin
        diff   <= shadow_full;
        borrow <= dsum[DIGIT];
      end
    end
  end

`ifdef SERIAL_SUB_FLAGS_EN
  // On the last digit the low digit of the operand shifters holds the operand MSBs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == RUN && last) begin
      zero <= (shadow_full == '0);
      ovf  <= (a_sh[DIGIT-1] != b_sh[DIGIT-1]) && (dsum[DIGIT-1] != a_sh[DIGIT-1]);
    end
  end
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - randomized self-checking bench for serial_subtractor
// Define SERIAL_SUB_FLAGS_EN to also check the zero/ovf outputs.
module tb_serial_subtractor;

  localparam int WIDTH = 24;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b1;
  logic             start  = 1'b0;
  logic             bin_in = 1'b0;
  logic [WIDTH-1:0] ain    = '0;
  logic [WIDTH-1:0] bin    = '0;
  logic             busy, done, borrow;
  logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUB_FLAGS_EN
  logic             zero, ovf;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .ain    (ain),
    .bin    (bin),
    .bin_in (bin_in),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero   (zero),
    .ovf    (ovf)
`endif
  );

  always #5 clk = ~clk;

  // Reference arithmetic: plain wide integer math on the unsigned and signed views.
  function automatic void ref_sub(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input logic c, output logic [WIDTH-1:0] d,
                                  output logic br, output logic z, output logic o);
    longint ua, ub, r, sa, sb, rs;
    ua = longint'(a);
    ub = longint'(b);
    r  = ua - ub - longint'(c);
    br = (r < 0);
    d  = r[WIDTH-1:0];
    z  = (d == '0);
    sa = a[WIDTH-1] ? ua - (longint'(1) << WIDTH) : ua;
    sb = b[WIDTH-1] ? ub - (longint'(1) << WIDTH) : ub;
    rs = sa - sb - longint'(c);
    o  = (rs > (longint'(1) << (WIDTH-1)) - 1) || (rs < -(longint'(1) << (WIDTH-1)));
  endfunction

  // Timing model: an accepted op keeps the unit busy for N+1 cycles, the last one being done.
  int               m_left   = 0;
  logic [WIDTH-1:0] m_diff   = '0, p_diff = '0;
  logic             m_borrow = 1'b0, p_borrow = 1'b0;
  logic             m_zero   = 1'b0, p_zero = 1'b0;
  logic             m_ovf    = 1'b0, p_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_diff = '0; m_borrow = 1'b0; m_zero = 1'b0; m_ovf = 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        ref_sub(ain, bin, bin_in, p_diff, p_borrow, p_zero, p_ovf);
        m_left = N + 1;
      end
    end else begin
      m_left = m_left - 1;
      if (m_left == 1) begin
        m_diff = p_diff; m_borrow = p_borrow; m_zero = p_zero; m_ovf = p_ovf;
      end
    end
  end

  always @(negedge clk) begin
    logic bad;
    n_cmp++;
    bad = (busy !== (m_left > 0)) || (done !== (m_left == 1)) ||
          (diff !== m_diff) || (borrow !== m_borrow);
`ifdef SERIAL_SUB_FLAGS_EN
    bad = bad || (zero !== m_zero) || (ovf !== m_ovf);
`endif
    if (bad) begin
      n_bad++;
      $display("FAIL cycle_model t=%0t got busy=%b done=%b diff=%h borrow=%b expected busy=%b done=%b diff=%h borrow=%b",
               $time, busy, done, diff, borrow, (m_left > 0), (m_left == 1), m_diff, m_borrow);
`ifdef SERIAL_SUB_FLAGS_EN
      $display("  flags got zero=%b ovf=%b expected zero=%b ovf=%b", zero, ovf, m_zero, m_ovf);
`endif
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
    @(posedge clk); #2;
    ain = a; bin = b; bin_in = c; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 4 * N; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
    if (cycles == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL done_timeout: got no done within %0d cycles expected a done pulse", 4 * N);
    end
  endtask

  initial begin
    int lat, pulses;
    #1 rst_n = 1'b0;
    #1 check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_diff", 64'(diff), 64'd0);
    check("reset_borrow", 64'(borrow), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    start_op(24'h000010, 24'h000001, 1'b0);
    wait_done(lat);
    check("t1_latency", 64'(lat), 64'(N + 1));
    check("t1_diff", 64'(diff), 64'h00000F);
    check("t1_borrow", 64'(borrow), 64'd0);

    start_op(24'h000000, 24'h000001, 1'b0);
    wait_done(lat);
    check("t2_diff", 64'(diff), 64'hFFFFFF);
    check("t2_borrow", 64'(borrow), 64'd1);
    repeat (5) @(negedge clk);
    check("t2_diff_held", 64'(diff), 64'hFFFFFF);

    start_op(24'h123456, 24'h123455, 1'b1);
    wait_done(lat);
    check("t3_diff", 64'(diff), 64'h000000);
    check("t3_borrow", 64'(borrow), 64'd0);
`ifdef SERIAL_SUB_FLAGS_EN
    check("t3_zero", 64'(zero), 64'd1);
`endif

    start_op(24'hABCDEF, 24'hFFFFFF, 1'b1);
    wait_done(lat);
    check("max_bin_diff", 64'(diff), 64'hABCDEF);
    check("max_bin_borrow", 64'(borrow), 64'd1);

    // Second start during RUN must be ignored.
    @(posedge clk); #2;
    ain = 24'd5; bin = 24'd3; bin_in = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    ain = 24'd9; bin = 24'd1;
    repeat (3) @(posedge clk);
    #2 start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("t4_done_pulses", 64'(pulses), 64'd1);
    check("t4_diff", 64'(diff), 64'h000002);

    // Reset in the cycle after E3.
    @(posedge clk); #2;
    ain = 24'h00F000; bin = 24'h000001; bin_in = 1'b0; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_done", 64'(done), 64'd0);
    check("t5_rst_diff", 64'(diff), 64'd0);
    check("t5_rst_borrow", 64'(borrow), 64'd0);
    @(posedge clk); #2 rst_n = 1'b1;
    start_op(24'd7, 24'd2, 1'b0);
    wait_done(lat);
    check("t5_after_diff", 64'(diff), 64'd5);
    check("t5_after_borrow", 64'(borrow), 64'd0);

`ifdef SERIAL_SUB_FLAGS_EN
    start_op(24'h7FFFFF, 24'hFFFFFF, 1'b0);
    wait_done(lat);
    check("t6_diff", 64'(diff), 64'h800000);
    check("t6_borrow", 64'(borrow), 64'd1);
    check("t6_ovf", 64'(ovf), 64'd1);
    check("t6_zero", 64'(zero), 64'd0);
`endif

    // Start held high continuously: back-to-back ops every N+2 cycles.
    @(posedge clk); #2;
    ain = 24'h000100; bin = 24'h000010; bin_in = 1'b1; start = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3 * (N + 2); i++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    check("held_start_pulses", 64'(pulses), 64'd3);
    @(posedge clk); #2 start = 1'b0;
    repeat (N + 3) @(posedge clk);

    // Random traffic, including extremes and occasional asynchronous reset.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #2;
      start  = ($urandom_range(0, 3) != 0);
      bin_in = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0:       ain = '0;
        1:       ain = '1;
        2:       ain = 24'h800000;
        default: ain = WIDTH'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       bin = '0;
        1:       bin = '1;
        2:       bin = 24'h7FFFFF;
        default: bin = WIDTH'($urandom);
      endcase
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
      end
    end
    start = 1'b0;
    repeat (N + 4) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
